// File: rtl/hop_cnt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// hop_cnt_rr_arbiter
// Registered hop-count arbiter for the switch output stage. The requester with
// the highest hop count wins. Ties are resolved by a round-robin scan that
// starts at the search start. The grant is held for a whole wormhole packet
// until its tail flit is accepted downstream.
//
// Optional feature: define HOP_ARB_AGING_EN to add per-input starvation age
// counters. Saturated requesters form a priority class above every hop count.
// -----------------------------------------------------------------------------
module hop_cnt_rr_arbiter #(
   parameter int unsigned IN_N      = 5,
   parameter int unsigned HOP_CNT_W = 3,
   parameter int unsigned AGE_W     = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [IN_N-1:0]               req_i,
   input  logic [IN_N*HOP_CNT_W-1:0]     hop_cnt_i,
   input  logic [IN_N-1:0]               tail_i,
   input  logic                          ack_i,
   output logic [IN_N-1:0]               gnt_o,
   output logic [$clog2(IN_N)-1:0]       gnt_id_o,
   output logic                          gnt_vld_o,
   output logic                          tie_o
);

   localparam int unsigned ID_W   = $clog2(IN_N);
   localparam int unsigned LEAF_N = 32'd1 << ID_W;
`ifdef HOP_ARB_AGING_EN
   // Top key bit marks the saturated-age priority class.
   localparam int unsigned KEY_W  = HOP_CNT_W + 32'd1;
   localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
`else
   localparam int unsigned KEY_W  = HOP_CNT_W;
`endif

   localparam logic [ID_W-1:0] ID_ZERO = {ID_W{1'b0}};
   localparam logic [ID_W-1:0] ID_ONE  = ID_W'(1);
   localparam logic [ID_W-1:0] ID_LAST = ID_W'(IN_N - 1);
   localparam logic [IN_N-1:0] VEC_ONE = IN_N'(1);
   localparam logic [ID_W:0]   SCAN_N  = (ID_W + 1)'(IN_N);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   // Registered state and outputs
   state_e           r_state;
   logic [IN_N-1:0]  r_gnt;
   logic [ID_W-1:0]  r_gnt_id;
   logic             r_vld;
   logic             r_tie;
   logic [ID_W-1:0]  r_rr_ptr;
`ifdef HOP_ARB_AGING_EN
   logic [AGE_W-1:0] r_age [IN_N];
`endif

   // Combinational arbitration signals
   logic [ID_W-1:0]  w_next_id;
   logic [ID_W-1:0]  w_start;
   logic             w_release;
   logic             w_any_req;
   logic             w_load;
   logic [KEY_W-1:0] w_key  [IN_N];
   logic [KEY_W-1:0] w_tree [2*LEAF_N];
   logic [KEY_W-1:0] w_max_key;
   logic [IN_N-1:0]  w_match;
   logic [ID_W:0]    w_idx;
   logic             w_found;
   logic [ID_W-1:0]  w_win_id;
   logic [IN_N-1:0]  w_win_vec;
   logic             w_tie;

   // Successor of the granted index (modulo IN_N) and the search start point
   always_comb begin
      if (r_gnt_id == ID_LAST) begin
         w_next_id = ID_ZERO;
      end else begin
         w_next_id = r_gnt_id + ID_ONE;
      end
      if (r_state == ST_LOCKED) begin
         w_start = w_next_id;
      end else begin
         w_start = r_rr_ptr;
      end
   end

   assign w_any_req = |req_i;
   assign w_release = (r_state == ST_LOCKED) & ack_i & tail_i[r_gnt_id];
   // A new winner is latched when idle with requests or when releasing into requests.
   assign w_load    = w_any_req & ((r_state == ST_IDLE) | w_release);

   // Key formation, log-depth max tree, tie detection and rotated first-match scan
   always_comb begin
      w_tree    = '{default: {KEY_W{1'b0}}};
      w_match   = {IN_N{1'b0}};
      w_found   = 1'b0;
      w_win_id  = ID_ZERO;
      w_idx     = {(ID_W+1){1'b0}};
      for (int i = 0; i < int'(IN_N); i++) begin
`ifdef HOP_ARB_AGING_EN
         if (r_age[i] == AGE_MAX) begin
            w_key[i] = {1'b1, {HOP_CNT_W{1'b0}}};
         end else begin
            w_key[i] = {1'b0, hop_cnt_i[i*HOP_CNT_W +: HOP_CNT_W]};
         end
`else
         w_key[i] = hop_cnt_i[i*HOP_CNT_W +: HOP_CNT_W];
`endif
         // Non-requesters contribute a zero leaf so they can never raise the max.
         if (req_i[i]) begin
            w_tree[int'(LEAF_N) + i] = w_key[i];
         end else begin
            w_tree[int'(LEAF_N) + i] = {KEY_W{1'b0}};
         end
      end
      for (int n = int'(LEAF_N) - 1; n >= 1; n--) begin
         if (w_tree[2*n] >= w_tree[2*n+1]) begin
            w_tree[n] = w_tree[2*n];
         end else begin
            w_tree[n] = w_tree[2*n+1];
         end
      end
      w_max_key = w_tree[1];
      for (int i = 0; i < int'(IN_N); i++) begin
         w_match[i] = req_i[i] & (w_key[i] == w_max_key);
      end
      for (int k = 0; k < int'(IN_N); k++) begin
         w_idx = {1'b0, w_start} + (ID_W+1)'(k);
         if (w_idx >= SCAN_N) begin
            w_idx = w_idx - SCAN_N;
         end else begin
            w_idx = w_idx;
         end
         if (!w_found && w_match[w_idx[ID_W-1:0]]) begin
            w_found  = 1'b1;
            w_win_id = w_idx[ID_W-1:0];
         end else begin
            w_found  = w_found;
         end
      end
   end

   // More than one set bit in the match vector means the tie-break decided.
   assign w_tie     = |(w_match & (w_match - VEC_ONE));
   assign w_win_vec = VEC_ONE << w_win_id;

   // Grant FSM: latch winners, hold for the packet, release on tail accept
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= ST_IDLE;
         r_gnt    <= {IN_N{1'b0}};
         r_gnt_id <= ID_ZERO;
         r_vld    <= 1'b0;
         r_tie    <= 1'b0;
         r_rr_ptr <= ID_ZERO;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_state  <= ST_LOCKED;
                  r_gnt    <= w_win_vec;
                  r_gnt_id <= w_win_id;
                  r_vld    <= 1'b1;
                  r_tie    <= w_tie;
               end else begin
                  r_state  <= ST_IDLE;
               end
            end
            ST_LOCKED: begin
               if (w_release) begin
                  r_rr_ptr <= w_next_id;
                  if (w_any_req) begin
                     r_state  <= ST_LOCKED;
                     r_gnt    <= w_win_vec;
                     r_gnt_id <= w_win_id;
                     r_vld    <= 1'b1;
                     r_tie    <= w_tie;
                  end else begin
                     r_state  <= ST_IDLE;
                     r_gnt    <= {IN_N{1'b0}};
                     r_gnt_id <= ID_ZERO;
                     r_vld    <= 1'b0;
                     r_tie    <= 1'b0;
                  end
               end else begin
                  r_state <= ST_LOCKED;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_gnt    <= {IN_N{1'b0}};
               r_gnt_id <= ID_ZERO;
               r_vld    <= 1'b0;
               r_tie    <= 1'b0;
               r_rr_ptr <= ID_ZERO;
            end
         endcase
      end
   end

`ifdef HOP_ARB_AGING_EN
   // Starvation ages: count waiting cycles, saturate, clear when granted
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(IN_N); i++) begin
            r_age[i] <= {AGE_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < int'(IN_N); i++) begin
            if (w_load && (w_win_id == ID_W'(i))) begin
               r_age[i] <= {AGE_W{1'b0}};
            end else if (req_i[i] && !r_gnt[i] && (r_age[i] != AGE_MAX)) begin
               r_age[i] <= r_age[i] + AGE_W'(1);
            end else begin
               r_age[i] <= r_age[i];
            end
         end
      end
   end
`endif

   assign gnt_o     = r_gnt;
   assign gnt_id_o  = r_gnt_id;
   assign gnt_vld_o = r_vld;
   assign tie_o     = r_tie;

endmodule

// File: tb/tb_hop_cnt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hop_cnt_rr_arbiter
// Self-checking bench: directed scenario tasks plus a randomized run compared
// against a behavioural model of the arbitration rules. HOP_ARB_AGING_EN
// selects the aging build (AGE_W=2) and enables the aging scenario.
// -----------------------------------------------------------------------------
module tb_hop_cnt_rr_arbiter;

   localparam int IN_N = 5;
   localparam int HW   = 3;
   localparam int IDW  = 3;
`ifdef HOP_ARB_AGING_EN
   localparam int AW   = 2;
   localparam int AMAX = 3;
`else
   localparam int AW   = 4;
`endif

   logic                clk;
   logic                rst_ni;
   logic [IN_N-1:0]     req_i;
   logic [IN_N*HW-1:0]  hop_cnt_i;
   logic [IN_N-1:0]     tail_i;
   logic                ack_i;
   logic [IN_N-1:0]     gnt_o;
   logic [IDW-1:0]      gnt_id_o;
   logic                gnt_vld_o;
   logic                tie_o;

   hop_cnt_rr_arbiter #(
      .IN_N      (IN_N),
      .HOP_CNT_W (HW),
      .AGE_W     (AW)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .req_i     (req_i),
      .hop_cnt_i (hop_cnt_i),
      .tail_i    (tail_i),
      .ack_i     (ack_i),
      .gnt_o     (gnt_o),
      .gnt_id_o  (gnt_id_o),
      .gnt_vld_o (gnt_vld_o),
      .tie_o     (tie_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Behavioural model state
   bit m_locked;
   int m_id;
   int m_tie;
   int m_rr;
   int m_age [IN_N];

   function automatic int hop_of(input int i);
      return int'(hop_cnt_i[i*HW +: HW]);
   endfunction

   // Priority score: saturated age beats any hop count.
   function automatic int score_of(input int i);
`ifdef HOP_ARB_AGING_EN
      if (m_age[i] >= AMAX) return 1000;
`endif
      return hop_of(i);
   endfunction

   task automatic model_arb(input int start, output int win, output int tie);
      int best;
      int cnt;
      bit found;
      int idx;
      best = -1; cnt = 0; found = 0; win = 0;
      for (int i = 0; i < IN_N; i++)
         if (req_i[i] && score_of(i) > best) best = score_of(i);
      for (int i = 0; i < IN_N; i++)
         if (req_i[i] && score_of(i) == best) cnt++;
      for (int k = 0; k < IN_N; k++) begin
         idx = (start + k) % IN_N;
         if (!found && req_i[idx] && score_of(idx) == best) begin
            found = 1; win = idx;
         end
      end
      tie = (cnt >= 2) ? 1 : 0;
   endtask

   task automatic model_reset();
      m_locked = 0; m_id = 0; m_tie = 0; m_rr = 0;
      for (int i = 0; i < IN_N; i++) m_age[i] = 0;
   endtask

   // Apply the arbitration rules for one clock edge using the inputs at that edge.
   task automatic model_step();
      int win;
      int tie;
      bit load;
      bit old_locked;
      int old_id;
      load = 0; win = 0; tie = 0;
      old_locked = m_locked; old_id = m_id;
      if (!m_locked) begin
         if (|req_i) begin model_arb(m_rr, win, tie); load = 1; end
      end else if (ack_i && tail_i[m_id]) begin
         m_rr = (m_id + 1) % IN_N;
         if (|req_i) begin model_arb(m_rr, win, tie); load = 1; end
         else m_locked = 0;
      end
`ifdef HOP_ARB_AGING_EN
      for (int i = 0; i < IN_N; i++) begin
         if (load && win == i) m_age[i] = 0;
         else if (req_i[i] && !(old_locked && old_id == i) && m_age[i] < AMAX) m_age[i]++;
      end
`endif
      if (load) begin m_locked = 1; m_id = win; m_tie = tie; end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_hops(input int h0, input int h1, input int h2, input int h3, input int h4);
      hop_cnt_i = {HW'(h4), HW'(h3), HW'(h2), HW'(h1), HW'(h0)};
   endtask

   task automatic apply_reset();
      rst_ni = 1'b0;
      req_i = '0; tail_i = '0; ack_i = 1'b0; hop_cnt_i = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      vec_cnt++; if (gnt_o !== 5'b00000) begin err_cnt++; $display("FAIL reset_gnt: got %b expected %b", gnt_o, 5'b00000); end
      vec_cnt++; if (gnt_id_o !== 3'd0) begin err_cnt++; $display("FAIL reset_id: got %0d expected 0", gnt_id_o); end
      vec_cnt++; if (gnt_vld_o !== 1'b0) begin err_cnt++; $display("FAIL reset_vld: got %b expected 0", gnt_vld_o); end
      vec_cnt++; if (tie_o !== 1'b0) begin err_cnt++; $display("FAIL reset_tie: got %b expected 0", tie_o); end
      // Grant input 2 and go mid-packet
      req_i = 5'b00100; set_hops(0, 0, 4, 0, 0);
      tick();
      vec_cnt++; if (gnt_o !== 5'b00100) begin err_cnt++; $display("FAIL reset_pre_gnt: got %b expected %b", gnt_o, 5'b00100); end
      ack_i = 1'b1; tail_i = 5'b00000;
      tick();
      ack_i = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      model_reset();
      vec_cnt++; if (gnt_o !== 5'b00000) begin err_cnt++; $display("FAIL async_rst_gnt: got %b expected %b", gnt_o, 5'b00000); end
      vec_cnt++; if (gnt_id_o !== 3'd0) begin err_cnt++; $display("FAIL async_rst_id: got %0d expected 0", gnt_id_o); end
      vec_cnt++; if (gnt_vld_o !== 1'b0) begin err_cnt++; $display("FAIL async_rst_vld: got %b expected 0", gnt_vld_o); end
      @(posedge clk);
      #2 rst_ni = 1'b1;
      tick();
      vec_cnt++; if (gnt_o !== 5'b00100) begin err_cnt++; $display("FAIL post_rst_gnt: got %b expected %b", gnt_o, 5'b00100); end
      vec_cnt++; if (gnt_id_o !== 3'd2) begin err_cnt++; $display("FAIL post_rst_id: got %0d expected 2", gnt_id_o); end
   endtask

   task automatic test_max_hop();
      apply_reset();
      // Single-flit packet on input 1, release into no requests: pointer moves to 2
      req_i = 5'b00010; set_hops(0, 0, 0, 0, 0);
      tick();
      req_i = 5'b00000; ack_i = 1'b1; tail_i = 5'b00010;
      tick();
      vec_cnt++; if (gnt_vld_o !== 1'b0) begin err_cnt++; $display("FAIL maxhop_idle: got %b expected 0", gnt_vld_o); end
      ack_i = 1'b0; tail_i = '0;
      req_i = 5'b11111; set_hops(1, 6, 3, 6, 2);
      tick();
      vec_cnt++; if (gnt_id_o !== 3'd3) begin err_cnt++; $display("FAIL maxhop_tie_id: got %0d expected 3", gnt_id_o); end
      vec_cnt++; if (tie_o !== 1'b1) begin err_cnt++; $display("FAIL maxhop_tie_flag: got %b expected 1", tie_o); end
      ack_i = 1'b1; tail_i = 5'b01000; set_hops(1, 7, 3, 6, 2);
      tick();
      vec_cnt++; if (gnt_id_o !== 3'd1) begin err_cnt++; $display("FAIL maxhop_unique_id: got %0d expected 1", gnt_id_o); end
      vec_cnt++; if (tie_o !== 1'b0) begin err_cnt++; $display("FAIL maxhop_unique_tie: got %b expected 0", tie_o); end
      vec_cnt++; if (gnt_o !== 5'b00010) begin err_cnt++; $display("FAIL maxhop_unique_gnt: got %b expected %b", gnt_o, 5'b00010); end
      ack_i = 1'b0; tail_i = '0;
   endtask

   task automatic test_packet_lock();
      apply_reset();
      req_i = 5'b00010; set_hops(0, 2, 0, 0, 0);
      tick();
      vec_cnt++; if (gnt_id_o !== 3'd1) begin err_cnt++; $display("FAIL lock_start_id: got %0d expected 1", gnt_id_o); end
      req_i = 5'b10010; set_hops(0, 2, 0, 0, 7); ack_i = 1'b1; tail_i = 5'b00000;
      for (int f = 0; f < 2; f++) begin
         tick();
         vec_cnt++; if (gnt_o !== 5'b00010) begin err_cnt++; $display("FAIL lock_hold_flit%0d: got %b expected %b", f + 1, gnt_o, 5'b00010); end
      end
      tail_i = 5'b00010;
      tick();
      vec_cnt++; if (gnt_id_o !== 3'd4) begin err_cnt++; $display("FAIL lock_next_id: got %0d expected 4", gnt_id_o); end
      vec_cnt++; if (gnt_vld_o !== 1'b1) begin err_cnt++; $display("FAIL lock_no_bubble: got %b expected 1", gnt_vld_o); end
      ack_i = 1'b0; tail_i = '0;
   endtask

   task automatic test_rr_fairness();
      int exp_id [6];
      exp_id = '{0, 1, 2, 3, 4, 0};
      apply_reset();
      req_i = 5'b11111; set_hops(3, 3, 3, 3, 3); tail_i = 5'b11111; ack_i = 1'b1;
      for (int n = 0; n < 6; n++) begin
         tick();
         vec_cnt++; if (gnt_id_o !== IDW'(exp_id[n])) begin err_cnt++; $display("FAIL rr_id_%0d: got %0d expected %0d", n, gnt_id_o, exp_id[n]); end
`ifdef HOP_ARB_AGING_EN
         vec_cnt++; if (tie_o !== 1'(m_tie)) begin err_cnt++; $display("FAIL rr_tie_%0d: got %b expected %0d", n, tie_o, m_tie); end
`else
         vec_cnt++; if (tie_o !== 1'b1) begin err_cnt++; $display("FAIL rr_tie_%0d: got %b expected 1", n, tie_o); end
`endif
      end
      req_i = '0; ack_i = 1'b0; tail_i = '0;
   endtask

   task automatic test_idle_return();
      apply_reset();
      req_i = 5'b00100; set_hops(0, 0, 5, 0, 0);
      tick();
      req_i = 5'b00000; ack_i = 1'b1; tail_i = 5'b00100;
      tick();
      vec_cnt++; if (gnt_vld_o !== 1'b0) begin err_cnt++; $display("FAIL idle_vld: got %b expected 0", gnt_vld_o); end
      vec_cnt++; if (gnt_o !== 5'b00000) begin err_cnt++; $display("FAIL idle_gnt: got %b expected %b", gnt_o, 5'b00000); end
      // Pointer now sits past index 2: equal requesters resolve to 3
      ack_i = 1'b0; tail_i = '0; req_i = 5'b11111; set_hops(2, 2, 2, 2, 2);
      tick();
      vec_cnt++; if (gnt_id_o !== 3'd3) begin err_cnt++; $display("FAIL idle_rr_ptr: got %0d expected 3", gnt_id_o); end
      req_i = '0;
   endtask

`ifdef HOP_ARB_AGING_EN
   task automatic test_aging();
      bit seen;
      seen = 0;
      apply_reset();
      req_i = 5'b11111; set_hops(0, 5, 5, 5, 5); tail_i = 5'b11111; ack_i = 1'b1;
      for (int n = 0; n < 8; n++) begin
         tick();
         vec_cnt++; if (gnt_id_o !== IDW'(m_id)) begin err_cnt++; $display("FAIL aging_id_%0d: got %0d expected %0d", n, gnt_id_o, m_id); end
         if (gnt_o[0] === 1'b1) seen = 1;
      end
      vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("FAIL aging_starved: input 0 granted %b expected 1", seen); end
      req_i = '0; ack_i = 1'b0; tail_i = '0;
   endtask
`endif

   task automatic test_random();
      logic [IN_N-1:0] e_gnt;
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         req_i = IN_N'($urandom);
         if (m_locked) req_i[m_id] = 1'b1;
         if ($urandom_range(0, 1) == 0) hop_cnt_i = (IN_N*HW)'($urandom);
         else for (int i = 0; i < IN_N; i++) hop_cnt_i[i*HW +: HW] = HW'($urandom_range(0, 1));
         tail_i = IN_N'($urandom);
         ack_i = ($urandom_range(0, 3) != 0);
         tick();
         e_gnt = m_locked ? (IN_N'(1) << m_id) : '0;
         vec_cnt++; if (gnt_o !== e_gnt) begin err_cnt++; $display("FAIL rand_gnt_%0d: got %b expected %b", n, gnt_o, e_gnt); end
         vec_cnt++; if (gnt_id_o !== (m_locked ? IDW'(m_id) : 3'd0)) begin err_cnt++; $display("FAIL rand_id_%0d: got %0d expected %0d", n, gnt_id_o, m_locked ? m_id : 0); end
         vec_cnt++; if (gnt_vld_o !== m_locked) begin err_cnt++; $display("FAIL rand_vld_%0d: got %b expected %b", n, gnt_vld_o, m_locked); end
         vec_cnt++; if (tie_o !== (m_locked ? 1'(m_tie) : 1'b0)) begin err_cnt++; $display("FAIL rand_tie_%0d: got %b expected %0d", n, tie_o, m_locked ? m_tie : 0); end
      end
      req_i = '0; ack_i = 1'b0; tail_i = '0;
   endtask

   initial begin
      rst_ni = 1'b0;
      req_i = '0; tail_i = '0; ack_i = 1'b0; hop_cnt_i = '0;
      model_reset();
      test_reset();
      test_max_hop();
      test_packet_lock();
      test_rr_fairness();
      test_idle_return();
`ifdef HOP_ARB_AGING_EN
      test_aging();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
